// File: rtl/store_unit.sv
// store_unit: executes SW/SH/SB against a word-wide synchronous data memory.
// SW writes the word directly; SH/SB read the word, merge the low half/byte
// of the register value into it and write the merged word back.
module store_unit #(
  parameter int READ_LATENCY = 1  // cycles from mem_rd to valid mem_rdata, 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  StoreOp,
  input  logic        start,
  input  logic [31:0] StoreAddr,
  input  logic [31:0] StoreData,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_SW  = 2'd0,
    OP_SH  = 2'd1,
    OP_SB  = 2'd2,
    OP_RSV = 2'd3
  } store_op_t;

  state_t      state, next_state;
  store_op_t   op_q;
  logic [15:0] data_q;     // only the low half/byte is ever merged
  logic [2:0]  wait_cnt;
  logic        wait_last;
  logic [31:0] keep_mask;
  logic [31:0] merged;

  assign wait_last = (state == WAIT) && (wait_cnt == 3'd1);

  // Bits of the fetched word that survive the merge.
  assign keep_mask = (op_q == OP_SH) ? 32'hFFFF_0000 : 32'hFFFF_FF00;
  assign merged    = (mem_rdata & keep_mask) | ({16'h0000, data_q} & ~keep_mask);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (store_op_t'(StoreOp))
            OP_SW:        next_state = WRITE;
            OP_SH, OP_SB: next_state = READ;
            default:      next_state = DONE;
          endcase
        end
      end
      READ:    next_state = WAIT;
      WAIT:    if (wait_last) next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      busy   <= (next_state != IDLE);
      done   <= (next_state == DONE);
      mem_rd <= (next_state == READ);
      mem_wr <= (next_state == WRITE);
    end
  end

  // Operand capture, wait counting and write-data formation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_SW;
      data_q    <= 16'h0000;
      wait_cnt  <= 3'd0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= store_op_t'(StoreOp);
            data_q   <= StoreData[15:0];
            mem_addr <= StoreAddr;
            if (store_op_t'(StoreOp) == OP_SW) mem_wdata <= StoreData;
          end
        end
        READ: wait_cnt <= 3'(READ_LATENCY);
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_last) mem_wdata <= merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed checks of store_unit with READ_LATENCY=1 and 3.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [31:0] addr, data;
  logic        start1, start3;

  logic        busy1, done1, rd1, wr1;
  logic [31:0] maddr1, wdata1, rdata1;
  logic        busy3, done3, rd3, wr3;
  logic [31:0] maddr3, wdata3, rdata3;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt1 = 0, wr_cnt3 = 0, rdwr_overlap = 0;
  int base;

  localparam logic [31:0] MEM_WORD = 32'h1122_3344;
  localparam logic [31:0] JUNK     = 32'hCAFE_F00D;

  logic       rdv1;
  logic [2:0] rdp3;

  always #5 clk = ~clk;

  store_unit #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .StoreOp(op), .start(start1),
    .StoreAddr(addr), .StoreData(data), .busy(busy1), .done(done1),
    .mem_addr(maddr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1)
  );

  store_unit #(.READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .StoreOp(op), .start(start3),
    .StoreAddr(addr), .StoreData(data), .busy(busy3), .done(done3),
    .mem_addr(maddr3), .mem_rd(rd3), .mem_wr(wr3), .mem_wdata(wdata3),
    .mem_rdata(rdata3)
  );

  // Memory read-data models: the word is only valid READ_LATENCY cycles after
  // mem_rd, junk otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdv1 <= 1'b0;
      rdp3 <= 3'b000;
    end else begin
      rdv1 <= rd1;
      rdp3 <= {rdp3[1:0], rd3};
    end
  end
  assign rdata1 = rdv1    ? MEM_WORD : JUNK;
  assign rdata3 = rdp3[2] ? MEM_WORD : JUNK;

  // Write-strobe counters and strobe-exclusivity monitor.
  always @(posedge clk) begin
    if (wr1) wr_cnt1 <= wr_cnt1 + 1;
    if (wr3) wr_cnt3 <= wr_cnt3 + 1;
    if ((rd1 && wr1) || (rd3 && wr3)) rdwr_overlap <= rdwr_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 2'd0; addr = '0; data = '0; start1 = 1'b0; start3 = 1'b0;
    tick; tick;
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_rdwr", {30'd0, rd1, wr1}, 32'd0);
    check("rst_addr", maddr1, 32'd0);
    check("rst_wdata", wdata1, 32'd0);
    reset = 1'b0;
    tick;

    // SW on u1
    op = 2'd0; addr = 32'h10; data = 32'hDEAD_BEEF; start1 = 1'b1;
    tick; start1 = 1'b0;                                    // cycle 1
    check("sw_c1_wr", {31'd0, wr1}, 32'd1);
    check("sw_c1_rd", {31'd0, rd1}, 32'd0);
    check("sw_c1_addr", maddr1, 32'h10);
    check("sw_c1_wdata", wdata1, 32'hDEAD_BEEF);
    check("sw_c1_busy", {31'd0, busy1}, 32'd1);
    tick;                                                   // cycle 2
    check("sw_c2_done", {31'd0, done1}, 32'd1);
    check("sw_c2_wr", {31'd0, wr1}, 32'd0);
    check("sw_c2_busy", {31'd0, busy1}, 32'd1);
    tick;                                                   // cycle 3
    check("sw_c3_busy", {31'd0, busy1}, 32'd0);
    check("sw_c3_done", {31'd0, done1}, 32'd0);
    check("sw_c3_addr_hold", maddr1, 32'h10);

    // SH on u1 with an ignored start while busy
    base = wr_cnt1;
    op = 2'd1; addr = 32'h20; data = 32'hAAAA_BBBB; start1 = 1'b1;
    tick;                                                   // cycle 1
    check("sh_c1_rd", {31'd0, rd1}, 32'd1);
    check("sh_c1_wr", {31'd0, wr1}, 32'd0);
    op = 2'd0; addr = 32'h99; data = 32'h0;                 // start still high: must be ignored
    tick; start1 = 1'b0;                                    // cycle 2 (WAIT)
    check("sh_c2_rd", {31'd0, rd1}, 32'd0);
    check("sh_c2_wr", {31'd0, wr1}, 32'd0);
    check("sh_c2_busy", {31'd0, busy1}, 32'd1);
    tick;                                                   // cycle 3
    check("sh_c3_wr", {31'd0, wr1}, 32'd1);
    check("sh_c3_wdata", wdata1, 32'h1122_BBBB);
    check("sh_c3_addr", maddr1, 32'h20);
    // start during the done cycle must be ignored
    op = 2'd3; start1 = 1'b1;
    tick;                                                   // cycle 4
    check("sh_c4_done", {31'd0, done1}, 32'd1);
    check("sh_c4_wr", {31'd0, wr1}, 32'd0);
    tick;                                                   // cycle 5: idle, start sampled here
    check("sh_c5_busy", {31'd0, busy1}, 32'd0);
    check("sh_one_write", wr_cnt1 - base, 32'd1);
    addr = 32'h50;
    tick; start1 = 1'b0;                                    // reserved op, cycle 1
    check("rsv_c1_done", {31'd0, done1}, 32'd1);
    check("rsv_c1_busy", {31'd0, busy1}, 32'd1);
    check("rsv_c1_rdwr", {30'd0, rd1, wr1}, 32'd0);
    check("rsv_c1_addr", maddr1, 32'h50);
    tick;
    check("rsv_c2_busy", {31'd0, busy1}, 32'd0);
    check("rsv_c2_rdwr", {30'd0, rd1, wr1}, 32'd0);
    check("rsv_no_write", wr_cnt1 - base, 32'd1);

    // SB on u3, READ_LATENCY=3: rd@1, wr@5, done@6, busy 1..6
    op = 2'd2; addr = 32'h30; data = 32'hFFFF_FF5A; start3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick; start3 = 1'b0;
      check($sformatf("sb_c%0d_busy", c), {31'd0, busy3}, {31'd0, (c <= 6)});
      check($sformatf("sb_c%0d_rd", c),   {31'd0, rd3},   {31'd0, (c == 1)});
      check($sformatf("sb_c%0d_wr", c),   {31'd0, wr3},   {31'd0, (c == 5)});
      check($sformatf("sb_c%0d_done", c), {31'd0, done3}, {31'd0, (c == 6)});
      if (c == 5) check("sb_wdata", wdata3, 32'h1122_335A);
    end

    // Reset in WAIT of an SB
    base = wr_cnt3;
    op = 2'd2; addr = 32'h34; data = 32'h0000_0077; start3 = 1'b1;
    tick; start3 = 1'b0;                                    // cycle 1 READ
    tick;                                                   // cycle 2 WAIT
    #2 reset = 1'b1;
    #1;
    check("rst_wait_busy", {31'd0, busy3}, 32'd0);
    check("rst_wait_rdwr", {30'd0, rd3, wr3}, 32'd0);
    check("rst_wait_done", {31'd0, done3}, 32'd0);
    check("rst_wait_addr", maddr3, 32'd0);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) tick;
    check("rst_no_write", wr_cnt3 - base, 32'd0);
    check("rst_idle_busy", {31'd0, busy3}, 32'd0);

    // SW after reset on u3
    op = 2'd0; addr = 32'h40; data = 32'h1234_5678; start3 = 1'b1;
    tick; start3 = 1'b0;
    check("sw2_c1_wr", {31'd0, wr3}, 32'd1);
    check("sw2_c1_wdata", wdata3, 32'h1234_5678);
    check("sw2_c1_addr", maddr3, 32'h40);
    tick;
    check("sw2_c2_done", {31'd0, done3}, 32'd1);
    tick;
    check("sw2_c3_busy", {31'd0, busy3}, 32'd0);
    check("sw2_one_write", wr_cnt3 - base, 32'd1);
    check("rdwr_exclusive", rdwr_overlap, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load-size extractor in the multicycle datapath.
- Performs SW/SH/SB into a word-wide memory:
  - SW is a direct word write.
  - SH/SB do a read-modify-write: fetch the word, replace the low 16/8 bits with register data, write the word back.
- Sits between the control unit (start/done handshake) and the synchronous data memory port.

Parameters:
- READ_LATENCY, 1, cycles from the cycle mem_rd is high to the cycle mem_rdata is valid (legal range 1..7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- StoreOp  input  2  0=SW, 1=SH, 2=SB, 3=reserved. Sampled with start.
- start  input  1  request pulse from control unit. Honoured only in IDLE.
- StoreAddr  input  32  word address. Sampled with start.
- StoreData  input  32  register value to store. Sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  32  address to memory. Holds the latched StoreAddr from start acceptance until the next accepted start.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_wdata  output  32  word to write. Valid while mem_wr=1.
- mem_rdata  input  32  memory read data.

Behaviour:
- All outputs are registered.
- Reset value of busy, done, mem_rd, mem_wr, mem_addr, mem_wdata and all internal registers is 0. State after reset is IDLE.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE, start=1:
  - Latch op, addr, data. mem_addr <= StoreAddr.
  - op=0 -> WRITE, mem_wdata <= StoreData.
  - op=1 or 2 -> READ.
  - op=3 -> DONE, no memory access.
- IDLE, start=0: stay in IDLE.
- READ: exactly one cycle. mem_rd=1. Next state WAIT; wait counter loaded with READ_LATENCY.
- WAIT: lasts READ_LATENCY cycles, mem_rd=0. On the clock edge ending the last WAIT cycle:
  - Sample mem_rdata.
  - Form mem_wdata:
    - SH: {mem_rdata[31:16], data[15:0]}.
    - SB: {mem_rdata[31:8], data[7:0]}.
  - Next state WRITE.
- WRITE: exactly one cycle. mem_wr=1 with mem_addr and mem_wdata stable. Next state DONE.
- DONE: exactly one cycle. done=1, busy=1. Next state IDLE.
- mem_rd and mem_wr are never high in the same cycle. Each is high for at most one cycle per operation.
- Latency, counted from the start-sampling edge (start sampled in IDLE at edge 0):
  - SW: mem_wr in cycle 1, done in cycle 2.
  - SH/SB: mem_rd in cycle 1, mem_wr in cycle 2+READ_LATENCY, done in cycle 3+READ_LATENCY.
  - Reserved op: done in cycle 1.
- start while busy=1:
  - Ignored, and not queued.
  - Latched operands do not change.
  - Input changes after acceptance do not affect the operation.
- start in the same cycle done=1: ignored (state is DONE, not IDLE). Earliest back-to-back start is the cycle after done.
- Reset mid-operation:
  - Immediate return to IDLE; all outputs forced to 0 asynchronously.
  - If reset is asserted during READ/WAIT, no write is issued.
  - If reset is asserted during WRITE, mem_wr drops asynchronously. Whether the memory commits that write is the memory's responsibility.
  - No done pulse for an aborted operation.
- Data bits above the selected width in StoreData are ignored for SH/SB.
- mem_rdata is ignored outside the last WAIT cycle.

Test Plan:
- SW: start, op=0, addr=0x10, data=0xDEADBEEF -> cycle1 mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle2 done=1; mem_rd never high.
- SH, READ_LATENCY=1: memory word 0x11223344, data=0xAAAABBBB -> cycle1 mem_rd=1; cycle3 mem_wr=1 with mem_wdata=0x1122BBBB; cycle4 done=1.
- SB, READ_LATENCY=3: memory word 0x11223344, data=0xFFFFFF5A -> mem_wr in cycle5 with mem_wdata=0x1122335A; done in cycle6; busy high cycles 1..6.
- Start ignored while busy: during an SH, pulse start with op=0, data=0x0 -> original SH completes unchanged, exactly one mem_wr and one done; then a start the cycle after done is accepted.
- Reset in WAIT of an SB -> busy, mem_rd, mem_wr and done go 0 without a clock edge; no mem_wr ever asserted; next SW works normally.
- Reserved op=3 -> done in cycle1; mem_rd and mem_wr stay 0 throughout.
